img_processor: RTL and testbench

- Streaming 3x3 convolution engine for 8-bit grayscale frames of IMG_W x IMG_H pixels, fed as an AXI-Stream raster.
- Builds a 3x3 window from two line buffers and applies the filter selected by kernel_type.
- Emits only the valid interior region, (IMG_H-2) x (IMG_W-2) pixels, as an AXI-Stream.
- Sits between the pixel source (DMA/camera) and the downstream sink in the image pipeline.

---
 rtl/img_processor_pkg.sv | 33 +++
 rtl/axi_stream_if.sv | 14 +
 rtl/img_processor_window.sv | 114 +++++++++++
 rtl/img_processor.sv | 116 +++++++++++
 tb/tb_img_processor.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/img_processor_pkg.sv
// Shared types, frame geometry and saturating helpers for the 3x3 convolution engine.
package img_processing_pkg;

    localparam int IMG_W            = 512;
    localparam int IMG_H            = 512;
    localparam int AXIS_TDATA_WIDTH = 8;
    localparam int AXIS_TUSER_WIDTH = 1;

    typedef enum logic [2:0] {
        KERNEL_IDENTITY  = 3'd0,
        KERNEL_GAUSSIAN  = 3'd1,
        KERNEL_SHARPEN   = 3'd2,
        KERNEL_SOBEL     = 3'd3,
        KERNEL_LAPLACIAN = 3'd4
    } kernel_type_t;

    function automatic logic [7:0] sat_u8(input logic signed [15:0] v);
        logic [7:0] r;
        if (v < 16'sd0) begin
            r = 8'd0;
        end else if (v > 16'sd255) begin
            r = 8'd255;
        end else begin
            r = v[7:0];
        end
        return r;
    endfunction

    function automatic logic signed [15:0] abs_s16(input logic signed [15:0] v);
        return (v < 16'sd0) ? -v : v;
    endfunction

endpackage

// File: rtl/axi_stream_if.sv
// Minimal AXI-Stream bundle used on both sides of the convolution engine.
interface axi_stream_if #(
    parameter int TDATA_WIDTH_P = 8,
    parameter int TUSER_WIDTH_P = 1
);
    logic [TDATA_WIDTH_P-1:0] tdata;
    logic                     tvalid;
    logic                     tready;
    logic                     tlast;
    logic [TUSER_WIDTH_P-1:0] tuser;

    modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
    modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/img_processor_window.sv
// 3x3 window builder: two line buffers, raster position counters and window shift registers.
module window_gen_3x3
    import img_processing_pkg::*;
#(
    parameter int DW      = AXIS_TDATA_WIDTH,
    parameter int IMG_W_P = IMG_W,
    parameter int IMG_H_P = IMG_H
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            en,
    input  logic            in_valid,
    input  logic [DW-1:0]   in_data,
    input  logic            in_sof,
    output logic [9*DW-1:0] win,
    output logic            win_valid,
    output logic            win_sof,
    output logic            win_eol
);
    localparam int CW = $clog2(IMG_W_P);
    localparam int RW = $clog2(IMG_H_P);

    logic [DW-1:0] lb_top_mem [IMG_W_P];
    logic [DW-1:0] lb_mid_mem [IMG_W_P];
    logic [CW-1:0] col_q, col_d, cur_col_s;
    logic [RW-1:0] row_q, row_d, cur_row_s;
    logic [DW-1:0] win_q [9];
    logic [DW-1:0] win_d [9];
    logic          win_valid_q, win_valid_d;
    logic          win_sof_q, win_sof_d;
    logic          win_eol_q, win_eol_d;
    logic          accept_s;

    assign accept_s = in_valid && en;

    // SOF overrides the counters; window index is 3*row+col with row 0 the oldest line
    always_comb begin
        cur_col_s   = in_sof ? '0 : col_q;
        cur_row_s   = in_sof ? '0 : row_q;
        col_d       = col_q;
        row_d       = row_q;
        win_d       = win_q;
        win_valid_d = win_valid_q;
        win_sof_d   = win_sof_q;
        win_eol_d   = win_eol_q;
        if (accept_s) begin
            if (cur_col_s == CW'(IMG_W_P - 1)) begin
                col_d = '0;
                if (cur_row_s == RW'(IMG_H_P - 1)) begin
                    row_d = '0;
                end else begin
                    row_d = cur_row_s + RW'(1);
                end
            end else begin
                col_d = cur_col_s + CW'(1);
                row_d = cur_row_s;
            end
            for (int r = 0; r < 3; r++) begin
                win_d[3*r]   = win_q[3*r+1];
                win_d[3*r+1] = win_q[3*r+2];
            end
            win_d[2]    = lb_top_mem[cur_col_s];
            win_d[5]    = lb_mid_mem[cur_col_s];
            win_d[8]    = in_data;
            win_valid_d = (cur_row_s >= RW'(2)) && (cur_col_s >= CW'(2));
            win_sof_d   = (cur_row_s == RW'(2)) && (cur_col_s == CW'(2));
            win_eol_d   = (cur_col_s == CW'(IMG_W_P - 1));
        end else if (en) begin
            win_valid_d = 1'b0;
        end else begin
            win_valid_d = win_valid_q;
        end
    end

    // Line buffers roll one row down per accepted pixel; contents are not reset
    always_ff @(posedge clk) begin
        if (accept_s) begin
            lb_top_mem[cur_col_s] <= lb_mid_mem[cur_col_s];
            lb_mid_mem[cur_col_s] <= in_data;
        end
    end

    // Position counters and window stage registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            col_q       <= '0;
            row_q       <= '0;
            win_valid_q <= 1'b0;
            win_sof_q   <= 1'b0;
            win_eol_q   <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            win_valid_q <= win_valid_d;
            win_sof_q   <= win_sof_d;
            win_eol_q   <= win_eol_d;
            win_q       <= win_d;
        end
    end

    always_comb begin
        for (int i = 0; i < 9; i++) begin
            win[i*DW +: DW] = win_q[i];
        end
    end

    assign win_valid = win_valid_q;
    assign win_sof   = win_sof_q;
    assign win_eol   = win_eol_q;

endmodule

// File: rtl/img_processor.sv
// Streaming 3x3 convolution: per-frame kernel latch, kernel arithmetic and AXI-Stream output register.
module img_processor
    import img_processing_pkg::*;
#(
    parameter int TDATA_WIDTH = AXIS_TDATA_WIDTH,
    parameter int TUSER_WIDTH = AXIS_TUSER_WIDTH,
    parameter int IMG_W_P     = IMG_W,
    parameter int IMG_H_P     = IMG_H
) (
    input  logic         clk,
    input  logic         resetn,
    input  kernel_type_t kernel_type,
    axi_stream_if.slave  s_axis,
    axi_stream_if.master m_axis
);
    logic                     en_s;
    logic                     sof_in_s;
    logic                     tlast_unused_s;
    logic [9*TDATA_WIDTH-1:0] win_s;
    logic                     win_valid_s, win_sof_s, win_eol_s;
    kernel_type_t             kernel_q, kernel_d;
    logic signed [15:0]       px_s [9];
    logic signed [15:0]       gauss_s, sharp_s, gx_s, gy_s, lap_s;
    logic [7:0]               res_s;
    logic                     tvalid_q, tvalid_d;
    logic                     tlast_q, tlast_d;
    logic                     tuser_q, tuser_d;
    logic [TDATA_WIDTH-1:0]   tdata_q, tdata_d;

    assign en_s           = !tvalid_q || m_axis.tready;
    assign s_axis.tready  = en_s;
    assign sof_in_s       = s_axis.tuser[0];
    assign tlast_unused_s = s_axis.tlast;

    window_gen_3x3 #(
        .DW      (TDATA_WIDTH),
        .IMG_W_P (IMG_W_P),
        .IMG_H_P (IMG_H_P)
    ) u_window (
        .clk       (clk),
        .resetn    (resetn),
        .en        (en_s),
        .in_valid  (s_axis.tvalid),
        .in_data   (s_axis.tdata),
        .in_sof    (sof_in_s),
        .win       (win_s),
        .win_valid (win_valid_s),
        .win_sof   (win_sof_s),
        .win_eol   (win_eol_s)
    );

    // Kernel arithmetic on the registered window; pixels are zero-extended to 16-bit signed
    always_comb begin
        for (int i = 0; i < 9; i++) begin
            px_s[i] = $signed(16'(win_s[i*TDATA_WIDTH +: TDATA_WIDTH]));
        end
        gauss_s = px_s[0] + 16'sd2 * px_s[1] + px_s[2]
                + 16'sd2 * px_s[3] + 16'sd4 * px_s[4] + 16'sd2 * px_s[5]
                + px_s[6] + 16'sd2 * px_s[7] + px_s[8];
        sharp_s = 16'sd5 * px_s[4] - px_s[1] - px_s[3] - px_s[5] - px_s[7];
        gx_s    = (px_s[2] + 16'sd2 * px_s[5] + px_s[8]) - (px_s[0] + 16'sd2 * px_s[3] + px_s[6]);
        gy_s    = (px_s[6] + 16'sd2 * px_s[7] + px_s[8]) - (px_s[0] + 16'sd2 * px_s[1] + px_s[2]);
        lap_s   = px_s[1] + px_s[3] + px_s[5] + px_s[7] - 16'sd4 * px_s[4];
        case (kernel_q)
            KERNEL_GAUSSIAN:  res_s = sat_u8(gauss_s >>> 4);
            KERNEL_SHARPEN:   res_s = sat_u8(sharp_s);
            KERNEL_SOBEL:     res_s = sat_u8(abs_s16(gx_s) + abs_s16(gy_s));
            KERNEL_LAPLACIAN: res_s = sat_u8(abs_s16(lap_s));
            default:          res_s = px_s[4][7:0];
        endcase
    end

    always_comb begin
        kernel_d = kernel_q;
        tvalid_d = tvalid_q;
        tdata_d  = tdata_q;
        tlast_d  = tlast_q;
        tuser_d  = tuser_q;
        if (s_axis.tvalid && en_s && sof_in_s) begin
            kernel_d = kernel_type;
        end else begin
            kernel_d = kernel_q;
        end
        if (en_s) begin
            tvalid_d = win_valid_s;
            tdata_d  = TDATA_WIDTH'(res_s);
            tlast_d  = win_valid_s && win_eol_s;
            tuser_d  = win_valid_s && win_sof_s;
        end else begin
            tvalid_d = tvalid_q;
        end
    end

    // Output register and per-frame kernel latch
    always_ff @(posedge clk) begin
        if (!resetn) begin
            kernel_q <= KERNEL_IDENTITY;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            tlast_q  <= 1'b0;
            tuser_q  <= 1'b0;
        end else begin
            kernel_q <= kernel_d;
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
            tlast_q  <= tlast_d;
            tuser_q  <= tuser_d;
        end
    end

    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tdata  = tdata_q;
    assign m_axis.tlast  = tlast_q;
    assign m_axis.tuser  = TUSER_WIDTH'(tuser_q);

endmodule

// File: tb/tb_img_processor.sv
// Self-checking bench for img_processor on a small 8x6 frame with a matrix-based reference model.
module tb_img_processor;
    import img_processing_pkg::*;

    localparam int W = 8;
    localparam int H = 6;

    typedef struct {
        int           pat;
        kernel_type_t k;
        kernel_type_t k2;
        int           chg;
        int           mode;
        int           gap;
        int           pidx;
        int           pexp;
    } vec_t;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    kernel_type_t kt = KERNEL_IDENTITY;
    int           n_cmp = 0;
    int           n_bad = 0;
    int           img [H][W];
    int           exp_q [$];
    int           got_q [$];
    int           rdy_mode = 0;
    int           cyc = 0;
    int           acc22_cyc = -1;
    int           sof_out_cyc = -1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    axi_stream_if #(.TDATA_WIDTH_P(8), .TUSER_WIDTH_P(1)) s_if ();
    axi_stream_if #(.TDATA_WIDTH_P(8), .TUSER_WIDTH_P(1)) m_if ();

    img_processor #(.IMG_W_P(W), .IMG_H_P(H)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .kernel_type (kt),
        .s_axis      (s_if),
        .m_axis      (m_if)
    );

    task automatic chk(input string name, input int act, input int want);
        n_cmp++;
        if (act != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, want);
        end
    endtask

    function automatic int coef(input int s, input int idx);
        int t [9];
        case (s)
            0:       t = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
            1:       t = '{0, -1, 0, -1, 5, -1, 0, -1, 0};
            2:       t = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
            3:       t = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};
            default: t = '{0, 1, 0, 1, -4, 1, 0, 1, 0};
        endcase
        return t[idx];
    endfunction

    function automatic int iabs(input int x);
        return (x < 0) ? -x : x;
    endfunction

    // Reference output for the window whose top-left pixel is (i,j)
    function automatic int ref_pix(input kernel_type_t k, input int i, input int j);
        int a [5];
        int v;
        for (int s = 0; s < 5; s++) begin
            a[s] = 0;
            for (int dy = 0; dy < 3; dy++)
                for (int dx = 0; dx < 3; dx++)
                    a[s] += coef(s, dy*3 + dx) * img[i+dy][j+dx];
        end
        case (k)
            KERNEL_GAUSSIAN:  v = a[0] / 16;
            KERNEL_SHARPEN:   v = a[1];
            KERNEL_SOBEL:     v = iabs(a[2]) + iabs(a[3]);
            KERNEL_LAPLACIAN: v = iabs(a[4]);
            default:          v = img[i+1][j+1];
        endcase
        if (v < 0) v = 0;
        if (v > 255) v = 255;
        return v;
    endfunction

    task automatic build_img(input int pat);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                case (pat)
                    0:       img[r][c] = 100;
                    1:       img[r][c] = (r*W + c) & 255;
                    2:       img[r][c] = (c < W/2) ? 0 : 200;
                    3:       img[r][c] = 80;
                    4:       img[r][c] = (r == 2 && c == 3) ? 255 : 0;
                    default: img[r][c] = int'($urandom_range(255));
                endcase
    endtask

    // Sink: drives tready per mode, collects beats, checks stall stability and input backpressure
    initial begin
        int prev_stall;
        int prev_beat;
        int cur;
        prev_stall  = 0;
        prev_beat   = 0;
        m_if.tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0) m_if.tready = 1'b1;
            else if (rdy_mode == 1) m_if.tready = ~m_if.tready;
            else m_if.tready = 1'($urandom_range(1));
            @(negedge clk);
            if (!resetn) begin
                prev_stall = 0;
            end else begin
                cur = int'({m_if.tvalid, m_if.tdata, m_if.tlast, m_if.tuser});
                if (prev_stall != 0) chk("stalled_beat_stable", cur, prev_beat);
                if (m_if.tvalid && !m_if.tready) chk("s_tready_low_on_stall", int'(s_if.tready), 0);
                if (m_if.tvalid && m_if.tready) begin
                    got_q.push_back(int'({m_if.tdata, m_if.tlast, m_if.tuser}));
                    if (m_if.tuser[0]) sof_out_cyc = cyc;
                end
                prev_stall = (m_if.tvalid && !m_if.tready) ? 1 : 0;
                prev_beat  = cur;
            end
        end
    end

    task automatic send_frame(input int npix, input int gap, input kernel_type_t k,
                              input kernel_type_t k2, input int chg);
        int r, c, t;
        bit acc;
        kt = k;
        for (int n = 0; n < npix; n++) begin
            r = n / W;
            c = n % W;
            if (gap > 0 && int'($urandom_range(99)) < gap) begin
                s_if.tvalid = 1'b0;
                @(posedge clk);
                #1;
            end
            s_if.tvalid = 1'b1;
            s_if.tdata  = 8'(img[r][c]);
            s_if.tuser  = (n == 0) ? 1'b1 : 1'b0;
            s_if.tlast  = (c == W-1) ? 1'b1 : 1'b0;
            acc = 1'b0;
            t   = 0;
            while (!acc && t < 1000) begin
                @(negedge clk);
                acc = s_if.tready;
                if (acc && n == 2*W + 2) acc22_cyc = cyc;
                @(posedge clk);
                #1;
                t++;
            end
            if (!acc) begin
                chk("input_accept_timeout", 0, 1);
                break;
            end
            if (n == chg) kt = k2;
        end
        s_if.tvalid = 1'b0;
        s_if.tuser  = 1'b0;
        s_if.tlast  = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int id);
        build_img(v.pat);
        rdy_mode = v.mode;
        exp_q.delete();
        for (int i = 0; i < H-2; i++)
            for (int j = 0; j < W-2; j++)
                exp_q.push_back((ref_pix(v.k, i, j) << 2) | ((j == W-3) ? 2 : 0) | ((i == 0 && j == 0) ? 1 : 0));
        got_q.delete();
        acc22_cyc   = -1;
        sof_out_cyc = -1;
        send_frame(H*W, v.gap, v.k, v.k2, v.chg);
        for (int t = 0; t < 2000 && got_q.size() < exp_q.size(); t++) @(posedge clk);
        repeat (8) @(posedge clk);
        #1;
        chk($sformatf("v%0d_beat_count", id), got_q.size(), (H-2)*(W-2));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("v%0d_beat%0d{data,last,user}", id, i), got_q[i], exp_q[i]);
        if (v.pidx >= 0 && v.pidx < got_q.size())
            chk($sformatf("v%0d_probe%0d", id, v.pidx), got_q[v.pidx] >> 2, v.pexp);
        if (v.mode == 0 && v.gap == 0)
            chk($sformatf("v%0d_first_out_latency", id), sof_out_cyc - acc22_cyc, 2);
    endtask

    initial begin
        vec_t vt [16];
        vec_t vr;
        s_if.tvalid = 1'b0;
        s_if.tdata  = 8'd0;
        s_if.tuser  = 1'b0;
        s_if.tlast  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_tvalid", int'(m_if.tvalid), 0);
        chk("reset_tdata", int'(m_if.tdata), 0);
        chk("reset_tlast", int'(m_if.tlast), 0);
        chk("reset_tuser", int'(m_if.tuser), 0);
        chk("reset_s_tready", int'(s_if.tready), 1);
        @(posedge clk);
        #1;
        resetn = 1'b1;

        vt[0]  = '{0, KERNEL_SOBEL,     KERNEL_SOBEL,     -1, 0, 0,  0, 0};
        vt[1]  = '{1, KERNEL_IDENTITY,  KERNEL_IDENTITY,  -1, 0, 0,  8, 19};
        vt[2]  = '{2, KERNEL_SOBEL,     KERNEL_SOBEL,     -1, 0, 0,  2, 255};
        vt[3]  = '{2, KERNEL_SOBEL,     KERNEL_SOBEL,     -1, 1, 0,  1, 0};
        vt[4]  = '{3, KERNEL_GAUSSIAN,  KERNEL_GAUSSIAN,  -1, 0, 0,  5, 80};
        vt[5]  = '{3, KERNEL_SHARPEN,   KERNEL_SHARPEN,   -1, 0, 0,  5, 80};
        vt[6]  = '{3, KERNEL_LAPLACIAN, KERNEL_LAPLACIAN, -1, 0, 0,  5, 0};
        vt[7]  = '{4, KERNEL_SHARPEN,   KERNEL_SHARPEN,   -1, 0, 0,  8, 255};
        vt[8]  = '{4, KERNEL_SHARPEN,   KERNEL_SHARPEN,   -1, 0, 0,  2, 0};
        vt[9]  = '{1, KERNEL_IDENTITY,  KERNEL_IDENTITY,  -1, 1, 0,  8, 19};
        vt[10] = '{5, KERNEL_GAUSSIAN,  KERNEL_GAUSSIAN,  -1, 2, 30, -1, 0};
        vt[11] = '{5, KERNEL_SOBEL,     KERNEL_SOBEL,     -1, 2, 30, -1, 0};
        vt[12] = '{5, KERNEL_LAPLACIAN, KERNEL_LAPLACIAN, -1, 1, 20, -1, 0};
        vt[13] = '{5, kernel_type_t'(3'd7), kernel_type_t'(3'd7), -1, 2, 10, -1, 0};
        vt[14] = '{5, KERNEL_SOBEL,     KERNEL_IDENTITY,  10, 0, 20, -1, 0};
        vt[15] = '{5, KERNEL_IDENTITY,  KERNEL_IDENTITY,  -1, 2, 0,  -1, 0};

        for (int v = 0; v < 16; v++) run_vec(vt[v], v);

        // Abandon a frame part-way through, then check reset values and a clean restart
        build_img(5);
        rdy_mode = 2;
        send_frame(3*W + 3, 0, KERNEL_SHARPEN, KERNEL_SHARPEN, -1);
        resetn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midreset_tvalid", int'(m_if.tvalid), 0);
        chk("midreset_tdata", int'(m_if.tdata), 0);
        chk("midreset_tlast", int'(m_if.tlast), 0);
        chk("midreset_tuser", int'(m_if.tuser), 0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        vr = '{5, KERNEL_GAUSSIAN, KERNEL_GAUSSIAN, -1, 1, 10, -1, 0};
        run_vec(vr, 16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
